// File: rtl/ecg_pkg.sv
// Shared types, state encoding and default timing constants for the ECG R-peak detector.
package ecg_pkg;

  localparam int DEF_DATAWIDTH = 64;
  localparam int DEF_CNTWIDTH  = 16;
  localparam int DEF_SEARCHWIN = 36;
  localparam int DEF_REFRACT   = 72;

  typedef logic signed [DEF_DATAWIDTH-1:0] sample_t;
  typedef logic        [DEF_DATAWIDTH-1:0] mag_t;
  typedef logic        [DEF_CNTWIDTH-1:0]  rr_t;

  typedef enum logic [1:0] {IDLE, SEARCH, REFRACT} pk_state_t;

endpackage

// File: rtl/ecg_rr_timer.sv
// Saturating sample-gap counter since the previous peak maximum, with candidate snapshot
// and rebase to the candidate position when a peak is declared.
module ecg_rr_timer #(
  parameter int CNTWIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic                capture,
  input  logic                declare,
  output logic [CNTWIDTH-1:0] cand_gap
);

  logic [CNTWIDTH-1:0] gap_q;
  logic [CNTWIDTH-1:0] gap_now;
  logic [CNTWIDTH-1:0] cand_q;

  // gap_now is the distance of the current sample from the previous peak maximum
  assign gap_now  = (gap_q == '1) ? gap_q : gap_q + CNTWIDTH'(1);
  assign cand_gap = capture ? gap_now : cand_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q  <= '0;
      cand_q <= '0;
    end else if (sample_valid) begin
      gap_q <= declare ? gap_now - cand_gap : gap_now;
      if (capture) cand_q <= gap_now;
    end
  end

endmodule

// File: rtl/ecg_peak_detect.sv
// R-peak detector: threshold crossing, windowed maximum search, refractory hold-off.
// Optional adaptive threshold from a running peak average: define ECG_ADAPTIVE_THRESH_EN.
module ecg_peak_detect
  import ecg_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int CNTWIDTH  = DEF_CNTWIDTH,
  parameter int SEARCHWIN = DEF_SEARCHWIN,
  parameter int REFRACT   = DEF_REFRACT
) (
  input  logic                        Clk,
  input  logic                        nRst,
  input  logic signed [DATAWIDTH-1:0] SampleIn,
  input  logic                        SampleValid,
  input  logic        [DATAWIDTH-1:0] Threshold,
  output logic                        PeakValid,
  output logic        [DATAWIDTH-1:0] PeakAmp,
  output logic        [CNTWIDTH-1:0]  RRInterval,
  output logic                        RRValid
);

  localparam int WW = $clog2(SEARCHWIN + 1);
  localparam int RW = $clog2(REFRACT + 1);
  localparam logic [DATAWIDTH-1:0] MAG_MAX = {1'b0, {(DATAWIDTH-1){1'b1}}};
  localparam logic [DATAWIDTH-1:0] MOST_NEG = {1'b1, {(DATAWIDTH-1){1'b0}}};

  pk_state_t state_q, state_d;
  logic [DATAWIDTH-1:0] mag, eff_thr, max_q, max_d, decl_amp;
  logic [WW-1:0]        win_q, win_d, win_inc;
  logic [RW-1:0]        ref_q, ref_d;
  logic                 above, declare, capture, first_q;
  logic [CNTWIDTH-1:0]  cand_gap;

  always_comb begin
    mag = SampleIn;
    if (SampleIn[DATAWIDTH-1]) mag = (SampleIn == MOST_NEG) ? MAG_MAX : -SampleIn;
  end

`ifdef ECG_ADAPTIVE_THRESH_EN
  logic [DATAWIDTH-1:0]      peak_avg;
  logic signed [DATAWIDTH:0] avg_diff;

  assign avg_diff = $signed({1'b0, decl_amp}) - $signed({1'b0, peak_avg});
  assign eff_thr  = (Threshold > (peak_avg >> 1)) ? Threshold : (peak_avg >> 1);

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst)        peak_avg <= '0;
    else if (declare) peak_avg <= peak_avg + DATAWIDTH'(avg_diff >>> 3);
  end
`else
  assign eff_thr = Threshold;
`endif

  assign above   = mag > eff_thr;
  assign win_inc = win_q + WW'(1);

  // A sample that both becomes the new maximum and ends the window is declared as the peak
  always_comb begin
    state_d  = state_q;
    max_d    = max_q;
    win_d    = win_q;
    ref_d    = ref_q;
    declare  = 1'b0;
    capture  = 1'b0;
    decl_amp = max_q;
    if (SampleValid) begin
      unique case (state_q)
        ecg_pkg::IDLE: begin
          if (above) begin
            state_d = ecg_pkg::SEARCH;
            capture = 1'b1;
            max_d   = mag;
            win_d   = WW'(1);
          end
        end
        ecg_pkg::SEARCH: begin
          if (!above) begin
            declare = 1'b1;
          end else begin
            if (mag > max_q) begin
              capture  = 1'b1;
              max_d    = mag;
              decl_amp = mag;
            end
            win_d = win_inc;
            if (win_inc == WW'(SEARCHWIN)) declare = 1'b1;
          end
          if (declare) begin
            state_d = ecg_pkg::REFRACT;
            ref_d   = RW'(REFRACT);
            win_d   = '0;
          end
        end
        ecg_pkg::REFRACT: begin
          ref_d = ref_q - RW'(1);
          if (ref_d == '0) state_d = ecg_pkg::IDLE;
        end
        default: state_d = ecg_pkg::IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) state_q <= ecg_pkg::IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      max_q      <= '0;
      win_q      <= '0;
      ref_q      <= '0;
      first_q    <= 1'b1;
      PeakValid  <= 1'b0;
      PeakAmp    <= '0;
      RRInterval <= '0;
      RRValid    <= 1'b0;
    end else begin
      max_q     <= max_d;
      win_q     <= win_d;
      ref_q     <= ref_d;
      PeakValid <= declare;
      if (declare) begin
        PeakAmp    <= decl_amp;
        RRInterval <= cand_gap;
        RRValid    <= !first_q;
        first_q    <= 1'b0;
      end
    end
  end

  ecg_rr_timer #(.CNTWIDTH(CNTWIDTH)) u_rr_timer (
    .clk          (Clk),
    .rst_n        (nRst),
    .sample_valid (SampleValid),
    .capture      (capture),
    .declare      (declare),
    .cand_gap     (cand_gap)
  );

endmodule
